// File: rtl/writeback_pkg.sv
// rtl/writeback_pkg.sv - shared writeback-source and FSM encodings plus entry layout
package writeback_pkg;

    // Writeback source select, shared with control and decode
    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC  = 2'b10,
        WB_IMM = 2'b11
    } wb_sel_e;

    // Writeback FSM states
    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_WAIT_MEM = 2'b01,
        ST_HALT     = 2'b10
    } wb_state_e;

    // One held pipeline entry coming from the MEM stage
    typedef struct packed {
        logic        valid;
        wb_sel_e     sel;
        logic        reg_write;
        logic [2:0]  wr_reg;
        logic [15:0] alu;
        logic [15:0] pc_inc;
        logic [15:0] imm;
        logic        halt;
    } wb_entry_t;

    // Picks the register write data for a given source select
    function automatic logic [15:0] wb_mux(
        input wb_sel_e     sel,
        input logic [15:0] alu,
        input logic [15:0] mem,
        input logic [15:0] pc_inc,
        input logic [15:0] imm
    );
        logic [15:0] r;
        case (sel)
            WB_ALU:  r = alu;
            WB_MEM:  r = mem;
            WB_PC:   r = pc_inc;
            default: r = imm;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/writeback_wb_latch.sv
// rtl/writeback_wb_latch.sv - pipeline entry register with load enable
module wb_latch
    import writeback_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      load,
    input  wb_entry_t entry_d,
    output wb_entry_t entry_q
);

    // Capture the next entry whenever the stage is not stalled; hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q <= '0;
        end else if (load) begin
            entry_q <= entry_d;
        end
    end

endmodule

// File: rtl/writeback.sv
// rtl/writeback.sv - writeback stage: retire FSM, source mux, retired counter
module writeback
    import writeback_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       in_wb_sel,
    input  logic             in_reg_write,
    input  logic [2:0]       in_wr_reg,
    input  logic [15:0]      in_alu,
    input  logic [15:0]      in_pc_inc,
    input  logic [15:0]      in_imm,
    input  logic             in_halt,
    input  logic             mem_done,
    input  logic [15:0]      mem_data,
    output logic             stall,
    output logic             regWrite,
    output logic [2:0]       writeReg,
    output logic [15:0]      writeData,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    wb_state_e        state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    wb_entry_t        entry_q, entry_d;
    logic             retire;

    wb_latch u_latch (
        .clk     (clk),
        .rst     (rst),
        .load    (~stall),
        .entry_d (entry_d),
        .entry_q (entry_q)
    );

    // Next entry: the presented instruction, or the current one marked empty
    always_comb begin
        entry_d       = entry_q;
        entry_d.valid = 1'b0;
        if (in_valid) begin
            entry_d.valid     = 1'b1;
            entry_d.sel       = wb_sel_e'(in_wb_sel);
            entry_d.reg_write = in_reg_write;
            entry_d.wr_reg    = in_wr_reg;
            entry_d.alu       = in_alu;
            entry_d.pc_inc    = in_pc_inc;
            entry_d.imm       = in_imm;
            entry_d.halt      = in_halt;
        end
    end

    // Retire decision, stall and next state; the cycle a pending load completes
    // drops stall so the following entry is taken on the retiring edge
    always_comb begin
        retire  = 1'b0;
        stall   = 1'b0;
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (entry_q.valid) begin
                    if (entry_q.sel == WB_MEM && !mem_done) begin
                        stall   = 1'b1;
                        state_d = ST_WAIT_MEM;
                    end else begin
                        retire = 1'b1;
                        if (entry_q.halt) state_d = ST_HALT;
                    end
                end
            end
            ST_WAIT_MEM: begin
                if (mem_done) begin
                    retire  = 1'b1;
                    state_d = entry_q.halt ? ST_HALT : ST_RUN;
                end else begin
                    stall = 1'b1;
                end
            end
            ST_HALT: begin
                stall = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};
    end

    // Register-file write port, live during the retiring cycle only
    always_comb begin
        regWrite  = 1'b0;
        writeReg  = 3'd0;
        writeData = 16'd0;
        if (retire) begin
            regWrite  = entry_q.reg_write & ~entry_q.halt;
            writeReg  = entry_q.wr_reg;
            writeData = wb_mux(entry_q.sel, entry_q.alu, mem_data,
                               entry_q.pc_inc, entry_q.imm);
        end
    end

    // FSM state and retired-instruction counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign halted  = (state_q == ST_HALT);
    assign retired = retired_q;

endmodule

// File: tb/tb_writeback.sv
// tb/tb_writeback.sv - directed scoreboard bench for writeback
module tb_writeback;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [1:0]       in_wb_sel;
    logic             in_reg_write;
    logic [2:0]       in_wr_reg;
    logic [15:0]      in_alu;
    logic [15:0]      in_pc_inc;
    logic [15:0]      in_imm;
    logic             in_halt;
    logic             mem_done;
    logic [15:0]      mem_data;
    logic             stall;
    logic             regWrite;
    logic [2:0]       writeReg;
    logic [15:0]      writeData;
    logic             halted;
    logic [CNT_W-1:0] retired;

    int checks = 0;
    int errors = 0;
    int exp_ret = 0;
    logic [18:0] sb_q[$];

    writeback #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_wb_sel    (in_wb_sel),
        .in_reg_write (in_reg_write),
        .in_wr_reg    (in_wr_reg),
        .in_alu       (in_alu),
        .in_pc_inc    (in_pc_inc),
        .in_imm       (in_imm),
        .in_halt      (in_halt),
        .mem_done     (mem_done),
        .mem_data     (mem_data),
        .stall        (stall),
        .regWrite     (regWrite),
        .writeReg     (writeReg),
        .writeData    (writeData),
        .halted       (halted),
        .retired      (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        in_valid     = 1'b0;
        in_wb_sel    = 2'b00;
        in_reg_write = 1'b0;
        in_wr_reg    = 3'd0;
        in_alu       = 16'h0;
        in_pc_inc    = 16'h0;
        in_imm       = 16'h0;
        in_halt      = 1'b0;
    endtask

    task automatic drive(input logic [1:0] sel, input logic rw, input logic [2:0] wr,
                         input logic [15:0] alu, input logic [15:0] pc,
                         input logic [15:0] imm, input logic hlt);
        in_valid     = 1'b1;
        in_wb_sel    = sel;
        in_reg_write = rw;
        in_wr_reg    = wr;
        in_alu       = alu;
        in_pc_inc    = pc;
        in_imm       = imm;
        in_halt      = hlt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sample at the falling edge; every register write must match the oldest expectation
    task automatic sample();
        logic [18:0] exp;
        @(negedge clk);
        if (regWrite === 1'b1) begin
            checks++;
            assert (sb_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected_write observed reg=%0d data=%h expected no write",
                       writeReg, writeData);
            end
            if (sb_q.size() != 0) begin
                exp = sb_q.pop_front();
                checks++;
                assert ({writeReg, writeData} === exp) else begin
                    errors++;
                    $error("FAIL sb_write observed reg=%0d data=%h expected reg=%0d data=%h",
                           writeReg, writeData, exp[18:16], exp[15:0]);
                end
            end
        end
    endtask

    initial begin
        idle();
        mem_done = 1'b0;
        mem_data = 16'h0;
        rst      = 1'b1;

        // Reset state
        #3;
        chk("rst_stall", stall, 0);
        chk("rst_regwrite", regWrite, 0);
        chk("rst_halted", halted, 0);
        chk("rst_retired", retired, 0);
        step(); rst = 1'b0; sample();
        chk("post_rst_stall", stall, 0);
        chk("post_rst_regwrite", regWrite, 0);

        // ALU op
        step(); drive(2'b00, 1, 3'd3, 16'h1234, 16'h0, 16'h0, 0);
        sb_q.push_back({3'd3, 16'h1234}); exp_ret++; sample();
        step(); idle(); sample();
        chk("alu_regwrite", regWrite, 1);
        chk("alu_stall", stall, 0);
        step(); sample();
        chk("alu_retired", retired, 1);
        chk("alu_idle_regwrite", regWrite, 0);

        // Load with two cycles of memory latency, ALU op queued behind it
        step(); drive(2'b01, 1, 3'd5, 16'h0, 16'h0, 16'h0, 0);
        sb_q.push_back({3'd5, 16'hBEEF}); exp_ret++; sample();
        step(); drive(2'b00, 1, 3'd2, 16'h5555, 16'h0, 16'h0, 0);
        sb_q.push_back({3'd2, 16'h5555}); exp_ret++; sample();
        chk("ld_wait1_stall", stall, 1);
        chk("ld_wait1_regwrite", regWrite, 0);
        step(); sample();
        chk("ld_wait2_stall", stall, 1);
        chk("ld_wait2_regwrite", regWrite, 0);
        step(); mem_done = 1'b1; mem_data = 16'hBEEF; sample();
        chk("ld_done_stall", stall, 0);
        chk("ld_done_regwrite", regWrite, 1);
        step(); idle(); mem_done = 1'b0; mem_data = 16'h0; sample();
        chk("b2b_regwrite", regWrite, 1);
        chk("b2b_writereg", writeReg, 3'd2);

        // JAL-type, then immediate with a stray mem_done, then a non-writing op
        step(); drive(2'b10, 1, 3'd7, 16'h0, 16'h0042, 16'h0, 0);
        sb_q.push_back({3'd7, 16'h0042}); exp_ret++; sample();
        step(); drive(2'b11, 1, 3'd1, 16'h9999, 16'h0, 16'hABCD, 0);
        mem_done = 1'b1; mem_data = 16'hFFFF;
        sb_q.push_back({3'd1, 16'hABCD}); exp_ret++; sample();
        chk("jal_writereg", writeReg, 3'd7);
        chk("jal_writedata", writeData, 16'h0042);
        step(); drive(2'b00, 0, 3'd2, 16'h3333, 16'h0, 16'h0, 0); exp_ret++; sample();
        chk("imm_writedata", writeData, 16'hABCD);
        chk("imm_stall", stall, 0);
        step(); idle(); mem_done = 1'b0; sample();
        chk("noreg_regwrite", regWrite, 0);

        // Load whose data is ready in its first cycle
        step(); drive(2'b01, 1, 3'd6, 16'h0, 16'h0, 16'h0, 0);
        sb_q.push_back({3'd6, 16'h0F0F}); exp_ret++; sample();
        step(); idle(); mem_done = 1'b1; mem_data = 16'h0F0F; sample();
        chk("fastld_stall", stall, 0);
        chk("fastld_regwrite", regWrite, 1);
        step(); mem_done = 1'b0; mem_data = 16'h0; sample();
        chk("basic_retired", retired, exp_ret % 16);
        chk("basic_stall", stall, 0);

        // Counter wrap: 17 back-to-back retirements from zero
        step(); rst = 1'b1; sample();
        step(); rst = 1'b0; exp_ret = 0; sample();
        for (int i = 0; i < 17; i++) begin
            step(); drive(2'b00, 0, 3'd0, 16'(i), 16'h0, 16'h0, 0); sample();
            if (i == 16) chk("wrap_all_ones", retired, 4'hF);
        end
        step(); idle(); sample();
        chk("wrap_zero", retired, 0);
        step(); sample();
        chk("wrap_one", retired, 1);
        exp_ret = 17;

        // HALT with reg_write set, followed by ALU ops that must not write
        step(); drive(2'b00, 1, 3'd4, 16'h7777, 16'h0, 16'h0, 1); exp_ret++; sample();
        step(); drive(2'b00, 1, 3'd6, 16'h1111, 16'h0, 16'h0, 0); sample();
        chk("halt_retire_regwrite", regWrite, 0);
        chk("halt_retire_halted", halted, 0);
        step(); sample();
        chk("halt_halted", halted, 1);
        chk("halt_stall", stall, 1);
        for (int i = 0; i < 3; i++) begin
            step(); sample();
            chk("halt_hold_stall", stall, 1);
            chk("halt_hold_regwrite", regWrite, 0);
        end
        chk("halt_retired", retired, exp_ret % 16);

        // Reset out of HALT
        step(); idle(); rst = 1'b1; sample();
        chk("rst_halt_halted", halted, 0);
        chk("rst_halt_stall", stall, 0);
        chk("rst_halt_retired", retired, 0);
        step(); rst = 1'b0; sample();

        // Reset in the middle of WAIT_MEM, then memory completes
        step(); drive(2'b01, 1, 3'd5, 16'h0, 16'h0, 16'h0, 0); sample();
        step(); idle(); sample();
        chk("abort_wait1_stall", stall, 1);
        step(); sample();
        chk("abort_wait2_stall", stall, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_rst_stall", stall, 0);
        chk("abort_rst_regwrite", regWrite, 0);
        chk("abort_rst_retired", retired, 0);
        mem_done = 1'b1; mem_data = 16'hDEAD;
        step(); rst = 1'b0; sample();
        chk("abort_done_regwrite", regWrite, 0);
        chk("abort_done_stall", stall, 0);
        step(); mem_done = 1'b0; sample();
        chk("abort_retired", retired, 0);
        chk("abort_halted", halted, 0);

        chk("sb_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback.md
WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 Parameter: CNT_W, 16, width of retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  MEM stage presents an instruction this cycle.
REQ-005 in_wb_sel  input  2  writeback source: 00 ALU, 01 memory, 10 PC+2, 11 immediate.
REQ-006 in_reg_write  input  1  instruction writes a register.
REQ-007 in_wr_reg  input  3  destination register, already resolved by the regDst encoding (may be R7).
REQ-008 in_alu  input  16  ALU result.
REQ-009 in_pc_inc  input  16  PC+2 of the instruction.
REQ-010 in_imm  input  16  extended immediate.
REQ-011 in_halt  input  1  instruction is HALT.
REQ-012 mem_done  input  1  load data valid on mem_data this cycle.
REQ-013 mem_data  input  16  load data.
REQ-014 stall  output  1  MEM stage must hold its outputs; the entry is not accepted.
REQ-015 regWrite  output  1  register-file write strobe.
REQ-016 writeReg  output  3  register-file write address.
REQ-017 writeData  output  16  register-file write data.
REQ-018 halted  output  1  processor halted.
REQ-019 retired  output  CNT_W  count of retired instructions.

Function
REQ-020 The block holds one pipeline entry register (valid, sel, reg_write, wr_reg, alu, pc_inc, imm, halt), loaded on the rising edge when in_valid=1 and stall=0; otherwise valid clears.
REQ-021 The FSM has three states: RUN, WAIT_MEM and HALT.
REQ-022 RUN: the held entry retires this cycle unless sel=01 and mem_done=0, in which case the FSM moves to WAIT_MEM.
REQ-023 WAIT_MEM: stall=1; the FSM stays in WAIT_MEM until mem_done=1, then the entry retires that cycle and the FSM returns to RUN.
REQ-024 On retirement: regWrite = reg_write; writeReg = wr_reg; writeData = the selected source (mem_data for sel=01).
REQ-025 Outside retirement: regWrite=0, writeReg=0, writeData=0.
REQ-026 regWrite, writeReg and writeData are combinational from the entry and state, so the write lands on the same edge that retires the entry.
REQ-027 stall = (state==WAIT_MEM) or (state==RUN and valid and sel=01 and mem_done=0) or (state==HALT).
REQ-028 Back-to-back loads: the next entry is accepted on the edge where the current load retires, with no bubble.
REQ-029 Retiring an entry with halt=1 moves the FSM to HALT and performs no register write, even if reg_write=1.
REQ-030 In HALT: halted=1, stall=1, regWrite=0; the FSM leaves HALT only on reset.
REQ-031 retired increments by 1 on every retirement (halt included) and wraps from all-ones to 0.
REQ-032 mem_done while not waiting on a load entry is ignored.
REQ-033 Decode-side bypass uses regWrite/writeReg/writeData directly; the block adds no extra bypass ports.

Reset
REQ-034 Asynchronous reset sets state=RUN, valid=0, all entry fields=0 and retired=0.
REQ-035 During and immediately after reset: regWrite=0, stall=0, halted=0.
REQ-036 Reset asserted in WAIT_MEM or HALT aborts the entry without writing a register.

Structure
REQ-037 The wb_sel encodings (WB_ALU, WB_MEM, WB_PC, WB_IMM) and the FSM state encodings are shared defines in the CPU package/include file, also used by control and decode.
REQ-038 The entry register is a sub-module wb_latch with load enable and async reset; the FSM, mux and counter live in writeback.

Verification
REQ-039 ALU op: in_valid=1, sel=00, reg_write=1, wr_reg=3, alu=16'h1234 -> one cycle later regWrite=1, writeReg=3, writeData=16'h1234, retired=1.
REQ-040 Load with 2-cycle memory latency: sel=01, wr_reg=5, mem_done low for 2 cycles, then mem_data=16'hBEEF -> stall high 2 cycles, regWrite high only in the mem_done cycle, writeData=16'hBEEF.
REQ-041 JAL-type: sel=10, wr_reg=7, pc_inc=16'h0042 -> writeReg=7, writeData=16'h0042.
REQ-042 HALT followed by ALU ops: halted=1, stall stays 1, no further regWrite, retired increments exactly once for the HALT.
REQ-043 Counter wrap: retired preset near all-ones via CNT_W=4, 17 retirements -> retired=1.
REQ-044 Reset mid-WAIT_MEM, then mem_done=1 -> regWrite never asserts, state=RUN, retired=0.
